// File: rtl/macish_mac_sched_if.sv
// Requester, result and MAC-side signal bundle for macish_mac_sched.
// The slave modport is the scheduler's view; master is the surrounding system.
interface macish_mac_sched_if #(
   parameter int LEN_W = 8
);
   logic             req0_valid, req1_valid;
   logic             req0_ready, req1_ready;
   logic [7:0]       req0_a, req0_b, req1_a, req1_b;
   logic             req0_last, req1_last;
   logic             res_valid, res_ready;
   logic [15:0]      res_data;
   logic             res_id;
   logic [LEN_W-1:0] res_count;
   logic             res_err;
   logic [7:0]       mac_dataa, mac_datab;
   logic             mac_clken, mac_sload;
   logic [15:0]      mac_adder_out;
   logic             busy;

   modport slave (
      input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
             req0_last, req1_last, res_ready, mac_adder_out,
      output req0_ready, req1_ready, res_valid, res_data, res_id, res_count,
             res_err, mac_dataa, mac_datab, mac_clken, mac_sload, busy
   );

   modport master (
      output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
             req0_last, req1_last, res_ready, mac_adder_out,
      input  req0_ready, req1_ready, res_valid, res_data, res_id, res_count,
             res_err, mac_dataa, mac_datab, mac_clken, mac_sload, busy
   );
endinterface

// File: rtl/macish_mac_sched.sv
// Round-robin scheduler sharing one macish MAC between two vector requesters.
// Optional stall timeout: define MACISH_MAC_SCHED_TIMEOUT_EN.
module macish_mac_sched #(
   parameter int MAC_LAT = 1,
   parameter int LEN_W   = 8,
   parameter int TO_CYC  = 16
) (
   input logic                 clk,
   input logic                 aclr,
   macish_mac_sched_if.slave   bus
);
   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] STREAM = 2'd1;
   localparam logic [1:0] DRAIN  = 2'd2;
   localparam logic [1:0] RESP   = 2'd3;

   localparam int DW = (MAC_LAT < 1) ? 1 : $clog2(MAC_LAT + 1);
   localparam logic [DW-1:0] DRAIN_END = DW'(MAC_LAT);

   if (MAC_LAT < 1 || TO_CYC < 1) begin : g_bad_param
      $error("macish_mac_sched: MAC_LAT and TO_CYC must be at least 1");
   end

   logic [1:0]       state;
   logic             gnt, last_gnt, first, err, grant_sel;
   logic [LEN_W-1:0] cnt;
   logic [DW-1:0]    dcnt;
   logic             sel_valid, sel_last, hs, stall_end;
   logic [7:0]       sel_a, sel_b;

   // Only the granted port is ever looked at.
   always_comb begin
      sel_valid = gnt ? bus.req1_valid : bus.req0_valid;
      sel_last  = gnt ? bus.req1_last  : bus.req0_last;
      sel_a     = gnt ? bus.req1_a     : bus.req0_a;
      sel_b     = gnt ? bus.req1_b     : bus.req0_b;
      hs        = (state == STREAM) && sel_valid;
      grant_sel = (bus.req0_valid && bus.req1_valid) ? ~last_gnt : bus.req1_valid;
   end

`ifdef MACISH_MAC_SCHED_TIMEOUT_EN
   localparam int TW = $clog2(TO_CYC + 1);
   logic [TW-1:0] to_cnt;

   assign stall_end = (state == STREAM) && !sel_valid && (to_cnt == TW'(TO_CYC - 1));

   always_ff @(posedge clk) begin
      if (!aclr || state != STREAM || hs) to_cnt <= '0;
      else                               to_cnt <= to_cnt + 1'b1;
   end
`else
   assign stall_end = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!aclr) begin
         state         <= IDLE;
         gnt           <= 1'b0;
         last_gnt      <= 1'b1;
         first         <= 1'b0;
         err           <= 1'b0;
         cnt           <= '0;
         dcnt          <= '0;
         bus.res_data  <= '0;
         bus.mac_dataa <= '0;
         bus.mac_datab <= '0;
         bus.mac_clken <= 1'b0;
         bus.mac_sload <= 1'b0;
      end else begin
         // Bubble cycles fall out of hs being low; dataa/datab just hold.
         bus.mac_clken <= hs;
         bus.mac_sload <= hs && first;
         case (state)
            IDLE: begin
               if (bus.req0_valid || bus.req1_valid) begin
                  gnt      <= grant_sel;
                  last_gnt <= grant_sel;
                  cnt      <= '0;
                  first    <= 1'b1;
                  err      <= 1'b0;
                  state    <= STREAM;
               end
            end
            STREAM: begin
               if (hs) begin
                  bus.mac_dataa <= sel_a;
                  bus.mac_datab <= sel_b;
                  first         <= 1'b0;
                  if (cnt != '1) cnt <= cnt + 1'b1;
                  if (sel_last) begin
                     dcnt  <= '0;
                     state <= DRAIN;
                  end
               end else if (stall_end) begin
                  err   <= 1'b1;
                  dcnt  <= '0;
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               // first still set means nothing reached the MAC this transaction.
               if (dcnt == DRAIN_END) begin
                  bus.res_data <= first ? '0 : bus.mac_adder_out;
                  state        <= RESP;
               end else begin
                  dcnt <= dcnt + 1'b1;
               end
            end
            default: begin
               if (bus.res_ready) state <= IDLE;
            end
         endcase
      end
   end

   always_comb begin
      bus.req0_ready = (state == STREAM) && !gnt;
      bus.req1_ready = (state == STREAM) && gnt;
      bus.res_valid  = (state == RESP);
      bus.res_id     = gnt;
      bus.res_count  = cnt;
      bus.res_err    = err;
      bus.busy       = (state != IDLE);
   end
endmodule

// File: tb/tb_macish_mac_sched.sv
// Directed bench for macish_mac_sched with an exact single-register MAC model.
// Timeout vectors run only when MACISH_MAC_SCHED_TIMEOUT_EN is defined.
module tb_macish_mac_sched;
   logic clk = 1'b0;
   logic aclr = 1'b0;
   int   n_checks = 0;
   int   n_fail = 0;

   macish_mac_sched_if #(.LEN_W(8)) bus ();

   macish_mac_sched #(.MAC_LAT(1), .LEN_W(8), .TO_CYC(16)) dut (
      .clk  (clk),
      .aclr (aclr),
      .bus  (bus.slave)
   );

   always #5 clk = ~clk;

   // Exact MAC: one accumulator register, output visible after the sampling edge.
   logic [15:0] acc;
   logic [15:0] prod;
   assign prod = {8'h00, bus.mac_dataa} * {8'h00, bus.mac_datab};
   assign bus.mac_adder_out = acc;
   always @(posedge clk) begin
      if (!aclr)              acc <= '0;
      else if (bus.mac_clken) acc <= bus.mac_sload ? prod : acc + prod;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One element on port id; returns 1ns after its accept edge.
   task automatic push(input bit id, input logic [7:0] a, input logic [7:0] b,
                       input bit last, input bit exp_sload);
      int k;
      if (id) begin
         bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b; bus.req1_last = last;
      end else begin
         bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b; bus.req0_last = last;
      end
      k = 0;
      while (!(id ? bus.req1_ready : bus.req0_ready) && k < 20) begin
         tick();
         k++;
      end
      if (!(id ? bus.req1_ready : bus.req0_ready)) begin
         check("ready_wait", 32'd0, 32'd1);
      end else begin
         tick();
         check("mac_clken", 32'(bus.mac_clken), 32'd1);
         check("mac_sload", 32'(bus.mac_sload), 32'(exp_sload));
         check("mac_dataa", 32'(bus.mac_dataa), 32'(a));
      end
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
   endtask

   task automatic wait_res(output int lat);
      lat = 0;
      while (!bus.res_valid && lat < 40) begin
         tick();
         lat++;
      end
      if (!bus.res_valid) check("res_wait", 32'd0, 32'd1);
   endtask

   task automatic expect_res(input string tag, input logic [15:0] data, input bit id,
                             input logic [7:0] count, input bit errv);
      check({tag, "_data"}, 32'(bus.res_data), 32'(data));
      check({tag, "_id"}, 32'(bus.res_id), 32'(id));
      check({tag, "_count"}, 32'(bus.res_count), 32'(count));
      check({tag, "_err"}, 32'(bus.res_err), 32'(errv));
   endtask

   task automatic consume();
      bus.res_ready = 1'b1;
      tick();
      bus.res_ready = 1'b0;
      check("idle_after_consume", 32'({bus.res_valid, bus.busy}), 32'd0);
   endtask

   task automatic check_all_zero(input string tag);
      check(tag, 32'({bus.busy, bus.req0_ready, bus.req1_ready, bus.res_valid,
                      bus.res_id, bus.res_err, bus.mac_clken, bus.mac_sload}), 32'd0);
      check({tag, "_buses"}, {bus.res_data, bus.mac_dataa, bus.mac_datab}, 32'd0);
      check({tag, "_count"}, 32'(bus.res_count), 32'd0);
   endtask

   initial begin
      int lat;
      bus.req0_valid = 0; bus.req1_valid = 0; bus.req0_last = 0; bus.req1_last = 0;
      bus.req0_a = 0; bus.req0_b = 0; bus.req1_a = 0; bus.req1_b = 0;
      bus.res_ready = 0;
      tick(); tick();
      check_all_zero("reset");
      aclr = 1'b1;
      tick();

      // Single element: 4*4
      push(1'b0, 8'd4, 8'd4, 1'b1, 1'b1);
      wait_res(lat);
      check("single_latency", 32'(lat), 32'd2);
      expect_res("single", 16'd16, 1'b0, 8'd1, 1'b0);
      consume();

      // Three elements from req1: 6+20+100
      push(1'b1, 8'd2, 8'd3, 1'b0, 1'b1);
      push(1'b1, 8'd4, 8'd5, 1'b0, 1'b0);
      push(1'b1, 8'd10, 8'd10, 1'b1, 1'b0);
      wait_res(lat);
      check("three_latency", 32'(lat), 32'd2);
      expect_res("three", 16'd126, 1'b1, 8'd3, 1'b0);
      consume();

      // Arbitration from reset with both requesters always valid
      aclr = 1'b0; tick(); aclr = 1'b1;
      bus.req0_valid = 1; bus.req0_a = 2; bus.req0_b = 3; bus.req0_last = 1;
      bus.req1_valid = 1; bus.req1_a = 5; bus.req1_b = 5; bus.req1_last = 1;
      for (int t = 0; t < 3; t++) begin
         bit exp_id;
         exp_id = (t == 1);
         tick();
         check("arb_ready", 32'({bus.req1_ready, bus.req0_ready}), exp_id ? 32'd2 : 32'd1);
         tick();
         wait_res(lat);
         check("arb_ready_in_resp", 32'({bus.req1_ready, bus.req0_ready}), 32'd0);
         expect_res("arb", exp_id ? 16'd25 : 16'd6, exp_id, 8'd1, 1'b0);
         if (t == 2) begin
            bus.req0_valid = 0;
            bus.req1_valid = 0;
         end
         consume();
      end

      // Bubbles: 2+12, three idle cycles, then 30
      push(1'b0, 8'd1, 8'd2, 1'b0, 1'b1);
      push(1'b0, 8'd3, 8'd4, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("bubble_clken", 32'(bus.mac_clken), 32'd0);
         check("bubble_hold", 32'({bus.mac_dataa, bus.mac_datab}), 32'h0304);
      end
      push(1'b0, 8'd5, 8'd6, 1'b1, 1'b0);
      wait_res(lat);
      expect_res("bubble", 16'd44, 1'b0, 8'd3, 1'b0);

      // Result backpressure with a competing request pending
      bus.req1_valid = 1; bus.req1_a = 1; bus.req1_b = 1; bus.req1_last = 1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("bp_state", 32'({bus.res_valid, bus.req1_ready, bus.req0_ready}), 32'd4);
         check("bp_data", 32'(bus.res_data), 32'd44);
      end
      bus.req1_valid = 0;
      consume();

      // Reset in the middle of a vector
      push(1'b0, 8'd9, 8'd9, 1'b0, 1'b1);
      aclr = 1'b0;
      tick();
      check_all_zero("mid_reset");
      aclr = 1'b1;
      push(1'b0, 8'd7, 8'd9, 1'b1, 1'b1);
      wait_res(lat);
      expect_res("after_reset", 16'd63, 1'b0, 8'd1, 1'b0);
      consume();

`ifdef MACISH_MAC_SCHED_TIMEOUT_EN
      // Stall after one element until the timeout closes the transaction
      push(1'b0, 8'd3, 8'd3, 1'b0, 1'b1);
      wait_res(lat);
      check("timeout_latency_min", 32'(lat >= 16), 32'd1);
      expect_res("timeout", 16'd9, 1'b0, 8'd1, 1'b1);
      consume();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/macish_mac_sched.md
# macish_mac_sched

Round-robin scheduler sharing one `macish` multiply-accumulate unit between two requesters. Each requester streams a vector of 8-bit operand pairs over a valid/ready handshake. The scheduler sequences the MAC's `dataa`/`datab`/`clken`/`sload` inputs and captures `adder_out` once the pipeline drains. It returns one 16-bit dot-product result per transaction, tagged with the requester ID.

## Interface
- `MAC_LAT`, 1: cycles from a registered MAC input being sampled to `adder_out` reflecting it.
- `LEN_W`, 8: width of the element counter.
- `TO_CYC`, 16: stall timeout in cycles; used only with `MACISH_MAC_SCHED_TIMEOUT_EN`.

Ports:
- `clk` in 1: clock, rising edge.
- `aclr` in 1: reset, synchronous, active-low.
- `req0_valid`, `req1_valid` in 1: element offered by requester 0/1.
- `req0_ready`, `req1_ready` out 1: element accepted.
- `req0_a`, `req0_b`, `req1_a`, `req1_b` in 8: operand pair.
- `req0_last`, `req1_last` in 1: element is last of vector.
- `res_valid` out 1: result available.
- `res_ready` in 1: result consumed.
- `res_data` out 16: captured `adder_out`.
- `res_id` out 1: requester that owns the result.
- `res_count` out LEN_W: elements accepted, saturating at 2^LEN_W-1.
- `res_err` out 1: transaction ended by timeout.
- `mac_dataa`, `mac_datab` out 8: to MAC `dataa`/`datab`.
- `mac_clken`, `mac_sload` out 1: to MAC `clken`/`sload`.
- `mac_adder_out` in 16: from MAC.
- `busy` out 1: high in any state other than IDLE.

## Operation
- States: IDLE, STREAM, DRAIN, RESP.
- **IDLE**
  - If any `reqN_valid`, grant one requester and move to STREAM.
  - Both valid: grant the requester not granted last.
  - After reset, the last-granted pointer is 1, so requester 0 wins first.
- **STREAM**
  - Only the granted `reqN_ready` is high. The other requester's ready stays low.
  - On handshake, register `a`/`b` into `mac_dataa`/`mac_datab` and set `mac_clken`=1 for the next cycle.
  - `mac_sload`=1 for the first element of the transaction, 0 otherwise.
  - No handshake: `mac_clken`=0 and `mac_sload`=0 next cycle (bubble); `mac_dataa`/`mac_datab` hold.
  - Each handshake increments the counter, saturating.
  - Handshake with `last`=1: move to DRAIN; ready drops the following cycle.
- **DRAIN**
  - Wait `MAC_LAT` cycles after the last element's MAC-input cycle.
  - Capture `mac_adder_out` into `res_data`, then move to RESP.
- **RESP**
  - `res_valid`=1; `res_data`/`res_id`/`res_count`/`res_err` held stable.
  - On `res_valid && res_ready`, return to IDLE next cycle.
  - No request is granted or accepted in DRAIN or RESP.
- Arithmetic:
  - `res_data` is the MAC output as-is; 16-bit wrap and approximation error are the MAC's.
  - `res_count` width is LEN_W; saturation does not end the transaction.

## Timing
- Reset: all outputs 0 (`res_*`, `mac_*`, ready, `busy`). State is IDLE and the pointer is 1.
- Reset mid-transaction abandons it: no result is produced and the counter is cleared.
- Grant edge to first possible accept: ready is high in the cycle after the IDLE→STREAM edge.
- Element accepted at edge E: MAC inputs are valid during cycle E..E+1 and the MAC samples at edge E+1.
- Last element accepted at edge E: `res_valid` rises after edge E+1+`MAC_LAT` (E+2 for the default).
- Minimum transaction for one element: grant, accept, `MAC_LAT`+1 cycles, RESP ≥1 cycle, IDLE 1 cycle.
- Request valid may drop or change between elements; the scheduler never samples non-granted ports.

## Configuration
- `MACISH_MAC_SCHED_TIMEOUT_EN` defined:
  - In STREAM, a counter increments per cycle without a handshake and clears on handshake.
  - Reaching `TO_CYC` moves to DRAIN as if `last` had been seen, with `res_err`=1.
  - With zero elements accepted, `res_data`=0 and the MAC is untouched.
- Undefined: no timeout logic; `res_err` is tied to 0; a stalled requester holds the MAC indefinitely.

## Test plan
The bench models `mac_adder_out` with an exact MAC, `MAC_LAT`=1.
- **Single element:** req0 sends (4,4,last) → `res_data`=16, `res_id`=0, `res_count`=1, `res_valid` rises 2 cycles after the accept edge.
- **Three elements:** req1 sends (2,3),(4,5),(10,10,last) → `mac_sload` is high only on the first element; `res_data`=126, `res_count`=3, `res_id`=1.
- **Arbitration:** both valid from reset over three back-to-back transactions → grant order 0, 1, 0; the non-granted ready never goes high.
- **Bubbles and backpressure:**
  - req0 drops valid for 3 cycles mid-vector → `mac_clken`=0 for those 3 cycles and the result is unchanged.
  - `res_ready` held low for 5 cycles → `res_valid` and `res_data` stay stable and no grant occurs.
- **Reset mid-stream:** `aclr`=0 for 1 cycle during a vector → all outputs 0 next cycle; the next transaction (7,9,last) yields 63.
- **Timeout (macro defined):** req0 stalls for 16 cycles after element (3,3) → `res_valid`, `res_err`=1, `res_data`=9, `res_count`=1.
